// File: rtl/nibble_byte_asm.sv
// Reassembles a low-nibble-first stream into bytes behind an OUT_DEPTH-entry output FIFO, counting delivered bytes.
// Optional NIB_ASM_PARITY_EN adds byte_par, the even parity of the head byte, stored per FIFO entry.
module nibble_byte_asm #(
    parameter int OUT_DEPTH = 2,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             nib_valid,
    output logic             nib_ready,
    input  logic [3:0]       nib_data,
    input  logic             nib_last,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic [7:0]       byte_data,
    output logic             byte_pad,
`ifdef NIB_ASM_PARITY_EN
    output logic             byte_par,
`endif
    output logic [CNT_W-1:0] byte_cnt
);
    localparam int PTR_W = $clog2(OUT_DEPTH);
`ifdef NIB_ASM_PARITY_EN
    localparam int ENT_W = 10;
`else
    localparam int ENT_W = 9;
`endif
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   OCC_ONE = 1;
    localparam logic [PTR_W:0]   OCC_MAX = OUT_DEPTH[PTR_W:0];
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic {LO, HI} state_t;

    state_t           state_q, state_d;
    logic [3:0]       lo_q, lo_d;
    logic [ENT_W-1:0] mem_q [OUT_DEPTH];
    logic [ENT_W-1:0] mem_d [OUT_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             full, accept, push, pop;
    logic [8:0]       push_ent;
    logic [ENT_W-1:0] head;

    // Full blocks the push even when a pop happens in the same cycle.
    assign full      = (occ_q == OCC_MAX);
    assign nib_ready = !full;
    assign accept    = nib_valid && !full;
    assign byte_valid = (occ_q != '0);
    assign pop       = byte_valid && byte_ready;

    assign head      = mem_q[rd_ptr_q];
    assign byte_data = head[7:0];
    assign byte_pad  = head[8];
`ifdef NIB_ASM_PARITY_EN
    assign byte_par  = head[9];
`endif
    assign byte_cnt  = cnt_q;

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        push     = 1'b0;
        push_ent = 9'h000;
        if (accept) begin
            if (state_q == LO) begin
                if (nib_last) begin
                    push     = 1'b1;
                    push_ent = {1'b1, 4'h0, nib_data};
                end else begin
                    lo_d    = nib_data;
                    state_d = HI;
                end
            end else begin
                push     = 1'b1;
                push_ent = {1'b0, nib_data, lo_q};
                state_d  = LO;
            end
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        cnt_d    = cnt_q;
        if (push) begin
`ifdef NIB_ASM_PARITY_EN
            mem_d[wr_ptr_q] = {^push_ent[7:0], push_ent};
`else
            mem_d[wr_ptr_q] = push_ent;
`endif
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            cnt_d    = cnt_q + CNT_ONE;
        end
        if (push && !pop) begin
            occ_d = occ_q + OCC_ONE;
        end else if (!push && pop) begin
            occ_d = occ_q - OCC_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= LO;
            lo_q     <= 4'h0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: tb/tb_nibble_byte_asm.sv
// Random and directed nibble streams checked cycle by cycle against a frame-level byte model.
module tb_nibble_byte_asm;
    localparam int DEPTH = 2;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          nib_valid = 1'b0;
    logic          nib_ready;
    logic [3:0]    nib_data = 4'h0;
    logic          nib_last = 1'b0;
    logic          byte_valid;
    logic          byte_ready = 1'b0;
    logic [7:0]    byte_data;
    logic          byte_pad;
`ifdef NIB_ASM_PARITY_EN
    logic          byte_par;
`endif
    logic [CW-1:0] byte_cnt;

    nibble_byte_asm #(.OUT_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .nib_valid(nib_valid), .nib_ready(nib_ready), .nib_data(nib_data), .nib_last(nib_last),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data), .byte_pad(byte_pad),
`ifdef NIB_ASM_PARITY_EN
        .byte_par(byte_par),
`endif
        .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // Stream to drive: per nibble, its value, last flag, and the {pad,data} it completes (if any).
    bit [3:0] s_nib[$];
    bit       s_last[$];
    bit       s_done[$];
    bit [8:0] s_byte[$];
    int       idx = 0;
    bit [8:0] exp_q[$];
    logic [CW-1:0] cnt_m = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A frame of len nibbles taken low-first from w; pairs form bytes, a trailing lone nibble is padded.
    task automatic add_frame(input logic [31:0] w, input int len);
        bit [3:0] n;
        bit [3:0] p;
        for (int i = 0; i < len; i++) begin
            n = w[4*i +: 4];
            s_nib.push_back(n);
            s_last.push_back(i == len - 1);
            if (i % 2 == 1) begin
                p = w[4*(i-1) +: 4];
                s_done.push_back(1'b1);
                s_byte.push_back({1'b0, n, p});
            end else if (i == len - 1) begin
                s_done.push_back(1'b1);
                s_byte.push_back({1'b1, 4'h0, n});
            end else begin
                s_done.push_back(1'b0);
                s_byte.push_back(9'h000);
            end
        end
    endtask

    task automatic clear_stream();
        s_nib.delete(); s_last.delete(); s_done.delete(); s_byte.delete();
        idx = 0;
    endtask

    // Called at a negedge: check outputs, drive next inputs, advance the model by one edge.
    task automatic step(input bit vld, input bit rdy);
        bit have, acc, pp;
        bit [8:0] e;
        check("nib_ready", 32'(nib_ready), 32'(exp_q.size() < DEPTH));
        check("byte_valid", 32'(byte_valid), 32'(exp_q.size() != 0));
        check("byte_cnt", 32'(byte_cnt), 32'(cnt_m));
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            check("head", {23'h0, byte_pad, byte_data}, {23'h0, e});
`ifdef NIB_ASM_PARITY_EN
            check("par", 32'(byte_par), 32'(^e[7:0]));
`endif
        end
        have = vld && (idx < s_nib.size());
        nib_valid  = have;
        nib_data   = have ? s_nib[idx] : 4'($urandom);
        nib_last   = have ? s_last[idx] : 1'($urandom);
        byte_ready = rdy;
        pp  = rdy && (exp_q.size() != 0);
        acc = have && (exp_q.size() < DEPTH);
        if (pp) begin
            void'(exp_q.pop_front());
            cnt_m = cnt_m + 1'b1;
        end
        if (acc) begin
            if (s_done[idx]) exp_q.push_back(s_byte[idx]);
            idx++;
        end
        @(negedge clk);
    endtask

    task automatic run(input int vld_pct, input int rdy_pct, input int hold);
        int cyc = 0;
        while ((idx < s_nib.size() || exp_q.size() != 0) && cyc < 4000) begin
            step($urandom_range(99, 0) < vld_pct, (cyc >= hold) && ($urandom_range(99, 0) < rdy_pct));
            cyc++;
        end
        check("drained", 32'(cyc < 4000), 32'd1);
        nib_valid  = 1'b0;
        byte_ready = 1'b0;
        clear_stream();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nib_valid = 1'b0;
        byte_ready = 1'b0;
        #1;
        check("rst_nib_ready", 32'(nib_ready), 32'd1);
        check("rst_byte_valid", 32'(byte_valid), 32'd0);
        check("rst_byte_data", 32'(byte_data), 32'd0);
        check("rst_byte_pad", 32'(byte_pad), 32'd0);
        check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
`ifdef NIB_ASM_PARITY_EN
        check("rst_byte_par", 32'(byte_par), 32'd0);
`endif
        exp_q.delete();
        cnt_m = '0;
        clear_stream();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Single byte 8'hA5
        add_frame(32'h0000_00A5, 2);
        run(100, 100, 0);
        check("t1_cnt", 32'(byte_cnt), 32'd1);

        // Three-nibble frame: 8'h21 then padded 8'h03
        do_reset();
        add_frame(32'h0000_0321, 3);
        run(100, 100, 0);
        check("t2_cnt", 32'(byte_cnt), 32'd2);

        // Back-pressure: six nibbles with consumer stalled, then released
        do_reset();
        add_frame(32'h0065_4321, 6);
        run(100, 100, 12);
        check("t3_cnt", 32'(byte_cnt), 32'd3);

        // Single-nibble frames push every cycle against a pop every cycle
        do_reset();
        for (int i = 0; i < 8; i++) add_frame(32'($urandom_range(15, 0)), 1);
        run(100, 100, 1);
        check("t4_cnt", 32'(byte_cnt), 32'd8);

        // Reset with a low nibble held; the partial byte must vanish
        do_reset();
        nib_valid = 1'b1; nib_data = 4'h5; nib_last = 1'b0;
        @(negedge clk);
        do_reset();
        add_frame(32'h0000_003C, 2);
        run(100, 100, 0);
        check("t5_cnt", 32'(byte_cnt), 32'd1);

        // Sixteen pops wrap the 4-bit counter to zero; first byte 8'h07 has odd weight
        do_reset();
        add_frame(32'h0000_0007, 2);
        for (int i = 0; i < 15; i++) add_frame($urandom, 2);
        run(100, 100, 0);
        check("t6_cnt_wrap", 32'(byte_cnt), 32'd0);

        // Random frames with random valid/ready
        do_reset();
        for (int i = 0; i < 40; i++) add_frame($urandom, $urandom_range(8, 1));
        run(70, 60, 0);
        check("t7_cnt", 32'(byte_cnt), 32'(cnt_m));
        check("t7_empty", 32'(byte_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
